// File: rtl/cfg_regs_pkg.sv
// Shared word map, response codes and FSM state types for the AXI4-Lite control/status bank.
// `VERSION can be overridden on the command line; it defaults to the value below.
`ifndef VERSION
`define VERSION 32'h0002_0100
`endif

package cfg_regs_pkg;

    localparam int VERSION_IDX    = 0;
    localparam int FLAGS_IDX      = 1;
    localparam int PULSE_IDX      = 2;
    localparam int EVENT_IDX      = 3;
    localparam int EVENT_MASK_IDX = 4;
    localparam int CTRL_BASE      = 5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    // Status words follow directly after the control words.
    function automatic int status_base(input int n_ctrl);
        return CTRL_BASE + n_ctrl;
    endfunction

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/axi_lite_slave_if.sv
// AXI4-Lite slave handshake: write FSM (IDLE/RESP) and read FSM (IDLE/DATA) feeding a simple
// register-core strobe interface. AW and W are only ever accepted together.
module axi_lite_slave_if
    import cfg_regs_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-3:0] wr_idx,
    output logic [31:0]           wr_data,
    output logic [3:0]            wr_strb,
    input  logic                  wr_err,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-3:0] rd_idx,
    input  logic [31:0]           rd_data,
    input  logic                  rd_err
);

    wr_state_t wr_state, wr_state_next;
    rd_state_t rd_state, rd_state_next;
    logic      wr_accept, rd_accept;
    logic      unused_ok;

    assign unused_ok = &{1'b0, s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_awprot, s_axi_arprot};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
        end else begin
            wr_state <= wr_state_next;
            rd_state <= rd_state_next;
        end
    end

    // Handshakes are gated by resetn so nothing is accepted while reset is held.
    always_comb begin
        wr_state_next = wr_state;
        wr_accept     = 1'b0;
        case (wr_state)
            WR_IDLE: if (resetn && s_axi_awvalid && s_axi_wvalid) begin
                wr_accept     = 1'b1;
                wr_state_next = WR_RESP;
            end
            WR_RESP: if (s_axi_bready) wr_state_next = WR_IDLE;
            default: wr_state_next = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_state_next = rd_state;
        rd_accept     = 1'b0;
        case (rd_state)
            RD_IDLE: if (resetn && s_axi_arvalid) begin
                rd_accept     = 1'b1;
                rd_state_next = RD_DATA;
            end
            RD_DATA: if (s_axi_rready) rd_state_next = RD_IDLE;
            default: rd_state_next = RD_IDLE;
        endcase
    end

    assign s_axi_awready = wr_accept;
    assign s_axi_wready  = wr_accept;
    assign s_axi_bvalid  = (wr_state == WR_RESP);
    assign s_axi_arready = rd_accept;
    assign s_axi_rvalid  = (rd_state == RD_DATA);

    assign wr_en   = wr_accept;
    assign wr_idx  = s_axi_awaddr[ADDR_WIDTH-1:2];
    assign wr_data = s_axi_wdata;
    assign wr_strb = s_axi_wstrb;
    assign rd_en   = rd_accept;
    assign rd_idx  = s_axi_araddr[ADDR_WIDTH-1:2];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s_axi_bresp <= RESP_OKAY;
            s_axi_rresp <= RESP_OKAY;
            s_axi_rdata <= '0;
        end else begin
            if (wr_accept) s_axi_bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
            if (rd_accept) begin
                s_axi_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
                s_axi_rdata <= rd_err ? '0 : rd_data;
            end
        end
    end

endmodule

// File: rtl/axi_ctrl_status_regs.sv
// Parametrised AXI4-Lite control/status register bank (RW, RO, W1P, W1C + masked irq).
// Optional feature macro CFG_REGS_SHADOW_EN: CTRL writes are staged and committed by PULSE bit 31.
module axi_ctrl_status_regs
    import cfg_regs_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int N_CTRL             = 4,
    parameter int N_STATUS           = 4,
    parameter int N_EVENTS           = 8
) (
    input  logic                            s_axi_aclk,
    input  logic                            s_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic                            run,
    output logic [31:0]                     flags,
    output logic [32*N_CTRL-1:0]            ctrl_out,
    input  logic [32*N_STATUS-1:0]          status_in,
    output logic [31:0]                     pulse_out,
    input  logic [N_EVENTS-1:0]             event_in,
    output logic                            irq
);

    localparam int IDX_W       = C_S_AXI_ADDR_WIDTH - 2;
    localparam int STATUS_BASE = status_base(N_CTRL);
    localparam int N_WORDS     = STATUS_BASE + N_STATUS;

    generate
        if (N_WORDS > (1 << IDX_W) || C_S_AXI_DATA_WIDTH != 32 || N_EVENTS < 1 || N_EVENTS > 32)
        begin : g_bad_cfg
            $error("axi_ctrl_status_regs: unsupported parameter combination");
        end
    endgenerate

    logic             wr_en, rd_en, wr_err, rd_err;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [31:0]      wr_data, rd_data;
    logic [3:0]       wr_strb;
    logic             unused_ok;

    axi_lite_slave_if #(.ADDR_WIDTH(C_S_AXI_ADDR_WIDTH)) u_if (
        .clk(s_axi_aclk), .resetn(s_axi_aresetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .wr_strb(wr_strb), .wr_err(wr_err),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data), .rd_err(rd_err)
    );

    logic [31:0]         flags_q, mask_q, pulse_q;
    logic [N_EVENTS-1:0] event_q, event_clr;
    logic                irq_q;
    logic [31:0]         ctrl_q   [N_CTRL];
    logic [31:0]         ctrl_view[N_CTRL];
    logic [31:0]         status_q [N_STATUS];
    logic [31:0]         wmask, wbits;
    int                  wr_ix, rd_ix;
    logic                pulse_hit;

    assign unused_ok = rd_en;
    assign wr_ix     = int'(wr_idx);
    assign rd_ix     = int'(rd_idx);
    assign wmask     = strb_mask(wr_strb);
    assign wbits     = wr_data & wmask;
    assign wr_err    = (wr_ix >= N_WORDS);
    assign pulse_hit = wr_en && (wr_ix == PULSE_IDX);
    assign event_clr = (wr_en && wr_ix == EVENT_IDX) ? wbits[N_EVENTS-1:0] : '0;

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            flags_q <= '0;
            mask_q  <= '0;
            pulse_q <= '0;
            event_q <= '0;
            irq_q   <= 1'b0;
            for (int i = 0; i < N_STATUS; i++) status_q[i] <= '0;
        end else begin
            pulse_q <= pulse_hit ? wbits : '0;
            if (wr_en && wr_ix == FLAGS_IDX)      flags_q <= (flags_q & ~wmask) | wbits;
            if (wr_en && wr_ix == EVENT_MASK_IDX) mask_q  <= (mask_q & ~wmask) | wbits;
            // A new event in the same cycle as its W1C clear keeps the bit set.
            event_q <= (event_q & ~event_clr) | event_in;
            irq_q   <= |(event_q & mask_q[N_EVENTS-1:0]);
            for (int i = 0; i < N_STATUS; i++) status_q[i] <= status_in[32*i +: 32];
        end
    end

`ifdef CFG_REGS_SHADOW_EN
    logic [31:0] shadow_q[N_CTRL];

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            for (int i = 0; i < N_CTRL; i++) begin
                shadow_q[i] <= '0;
                ctrl_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_CTRL; i++) begin
                if (wr_en && wr_ix == CTRL_BASE + i)
                    shadow_q[i] <= (shadow_q[i] & ~wmask) | wbits;
                if (pulse_hit && wbits[31])
                    ctrl_q[i] <= shadow_q[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_CTRL; i++) ctrl_view[i] = shadow_q[i];
    end
`else
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            for (int i = 0; i < N_CTRL; i++) ctrl_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_CTRL; i++) begin
                if (wr_en && wr_ix == CTRL_BASE + i)
                    ctrl_q[i] <= (ctrl_q[i] & ~wmask) | wbits;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_CTRL; i++) ctrl_view[i] = ctrl_q[i];
    end
`endif

    // Read mux sees register state before any write committing in the same cycle.
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        if (rd_ix == VERSION_IDX)         rd_data = `VERSION;
        else if (rd_ix == FLAGS_IDX)      rd_data = flags_q;
        else if (rd_ix == EVENT_IDX)      rd_data = 32'(event_q);
        else if (rd_ix == EVENT_MASK_IDX) rd_data = mask_q;
        else if (rd_ix >= N_WORDS)        rd_err  = 1'b1;
        for (int i = 0; i < N_CTRL; i++)
            if (rd_ix == CTRL_BASE + i) rd_data = ctrl_view[i];
        for (int i = 0; i < N_STATUS; i++)
            if (rd_ix == STATUS_BASE + i) rd_data = status_q[i];
    end

    generate
        for (genvar i = 0; i < N_CTRL; i++) begin : g_ctrl_out
            assign ctrl_out[32*i +: 32] = ctrl_q[i];
        end
    endgenerate

    assign flags     = flags_q;
    assign run       = flags_q[0];
    assign pulse_out = pulse_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_axi_ctrl_status_regs.sv
// Self-checking bench for axi_ctrl_status_regs: directed scenarios plus randomized traffic
// compared against a transaction-level model of the register map.
`ifndef VERSION
`define VERSION 32'h0002_0100
`endif

module tb_axi_ctrl_status_regs;

    localparam int N_CTRL   = 4;
    localparam int N_STATUS = 4;
    localparam int N_EVENTS = 8;
    localparam int N_MAPPED = 5 + N_CTRL + N_STATUS;

    logic                  clk = 1'b0;
    logic                  aresetn;
    logic [5:0]            s_axi_awaddr, s_axi_araddr;
    logic [2:0]            s_axi_awprot, s_axi_arprot;
    logic                  s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
    logic [31:0]           s_axi_wdata, s_axi_rdata;
    logic [3:0]            s_axi_wstrb;
    logic [1:0]            s_axi_bresp, s_axi_rresp;
    logic                  s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic                  s_axi_rvalid, s_axi_rready;
    logic                  run, irq;
    logic [31:0]           flags, pulse_out;
    logic [32*N_CTRL-1:0]  ctrl_out;
    logic [32*N_STATUS-1:0] status_in;
    logic [N_EVENTS-1:0]   event_in;

    int error_count = 0;
    int check_count = 0;

    logic [31:0]         mdl_flags, mdl_mask;
    logic [N_EVENTS-1:0] mdl_event;
    logic [31:0]         mdl_ctrl[N_CTRL];
    logic [31:0]         mdl_ctrl_out[N_CTRL];

    always #5 clk = ~clk;

    axi_ctrl_status_regs #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6),
        .N_CTRL(N_CTRL), .N_STATUS(N_STATUS), .N_EVENTS(N_EVENTS)
    ) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .run(run), .flags(flags), .ctrl_out(ctrl_out), .status_in(status_in),
        .pulse_out(pulse_out), .event_in(event_in), .irq(irq)
    );

    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] byteMask(input logic [3:0] strb);
        logic [31:0] m = '0;
        for (int b = 0; b < 4; b++) if (strb[b]) m = m | (32'hFF << (8 * b));
        return m;
    endfunction

    function automatic logic [127:0] expectedCtrlOut();
        logic [127:0] v = '0;
        for (int i = 0; i < N_CTRL; i++) v[32*i +: 32] = mdl_ctrl_out[i];
        return v;
    endfunction

    task automatic modelReset();
        mdl_flags = '0;
        mdl_mask  = '0;
        mdl_event = '0;
        for (int i = 0; i < N_CTRL; i++) begin
            mdl_ctrl[i]     = '0;
            mdl_ctrl_out[i] = '0;
        end
    endtask

    // Effect of one complete write on the register map; event_in is held during the transaction.
    task automatic modelWrite(input int idx, input logic [31:0] data, input logic [3:0] strb,
                              output logic [1:0] resp, output logic [31:0] pulse);
        logic [31:0] m;
        logic [31:0] v;
        m     = byteMask(strb);
        v     = data & m;
        resp  = 2'b00;
        pulse = '0;
        if (idx >= N_MAPPED) resp = 2'b10;
        else if (idx == 1) mdl_flags = (mdl_flags & ~m) | v;
        else if (idx == 2) begin
            pulse = v;
`ifdef CFG_REGS_SHADOW_EN
            if (v[31]) for (int i = 0; i < N_CTRL; i++) mdl_ctrl_out[i] = mdl_ctrl[i];
`endif
        end
        else if (idx == 3) mdl_event = (mdl_event & ~v[N_EVENTS-1:0]) | event_in;
        else if (idx == 4) mdl_mask = (mdl_mask & ~m) | v;
        else if (idx >= 5 && idx < 5 + N_CTRL) begin
            mdl_ctrl[idx-5] = (mdl_ctrl[idx-5] & ~m) | v;
`ifndef CFG_REGS_SHADOW_EN
            mdl_ctrl_out[idx-5] = mdl_ctrl[idx-5];
`endif
        end
        mdl_event = mdl_event | event_in;
    endtask

    function automatic logic [33:0] modelRead(input int idx);
        if (idx == 0) return {2'b00, `VERSION};
        if (idx == 1) return {2'b00, mdl_flags};
        if (idx == 2) return {2'b00, 32'h0};
        if (idx == 3) return {2'b00, 32'(mdl_event)};
        if (idx == 4) return {2'b00, mdl_mask};
        if (idx >= 5 && idx < 5 + N_CTRL) return {2'b00, mdl_ctrl[idx-5]};
        if (idx >= 5 + N_CTRL && idx < N_MAPPED) return {2'b00, status_in[32*(idx-5-N_CTRL) +: 32]};
        return {2'b10, 32'h0};
    endfunction

    function automatic logic expectedIrq();
        return |(mdl_event & mdl_mask[N_EVENTS-1:0]);
    endfunction

    // Caller is 1ns after a rising edge; returns 1ns after the edge that retires the response.
    task automatic axiWrite(input int idx, input logic [31:0] data, input logic [3:0] strb,
                            input int hold, input bit finish_resp);
        logic [1:0]  exp_resp;
        logic [31:0] exp_pulse;
        int n;
        s_axi_awaddr  = 6'(idx * 4);
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_bready  = 1'b0;
        #1;
        n = 0;
        while (!(s_axi_awready && s_axi_wready) && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("aw_w_accept", s_axi_awready && s_axi_wready, 1'b1);
        modelWrite(idx, data, strb, exp_resp, exp_pulse);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        checkOutput("bvalid_t1", s_axi_bvalid, 1'b1);
        checkOutput("bresp", s_axi_bresp, exp_resp);
        checkOutput("pulse_t1", pulse_out, exp_pulse);
        checkOutput("flags_t1", flags, mdl_flags);
        checkOutput("run_t1", run, mdl_flags[0]);
        checkOutput("ctrl_out_t1", ctrl_out, expectedCtrlOut());
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            s_axi_awaddr  = 6'(4);
            s_axi_wdata   = ~mdl_flags;
            s_axi_wstrb   = 4'hF;
            s_axi_awvalid = 1'b1;
            s_axi_wvalid  = 1'b1;
            #1;
            checkOutput("no_accept_in_resp", s_axi_awready | s_axi_wready, 1'b0);
            checkOutput("bvalid_held", s_axi_bvalid, 1'b1);
            checkOutput("pulse_gone", pulse_out, 32'h0);
            s_axi_awvalid = 1'b0;
            s_axi_wvalid  = 1'b0;
        end
        if (finish_resp) begin
            s_axi_bready = 1'b1;
            @(posedge clk); #1;
            s_axi_bready = 1'b0;
            checkOutput("bvalid_clear", s_axi_bvalid, 1'b0);
            checkOutput("pulse_zero", pulse_out, 32'h0);
        end
    endtask

    task automatic axiRead(input int idx, input int hold);
        logic [33:0] exp;
        int n;
        exp           = modelRead(idx);
        s_axi_araddr  = 6'(idx * 4);
        s_axi_arvalid = 1'b1;
        s_axi_rready  = 1'b0;
        #1;
        n = 0;
        while (!s_axi_arready && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("ar_accept", s_axi_arready, 1'b1);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        checkOutput("rvalid", s_axi_rvalid, 1'b1);
        checkOutput($sformatf("rdata_w%0d", idx), s_axi_rdata, exp[31:0]);
        checkOutput($sformatf("rresp_w%0d", idx), s_axi_rresp, exp[33:32]);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            checkOutput("rvalid_held", s_axi_rvalid, 1'b1);
            checkOutput("rdata_stable", s_axi_rdata, exp[31:0]);
        end
        s_axi_rready = 1'b1;
        @(posedge clk); #1;
        s_axi_rready = 1'b0;
        checkOutput("rvalid_clear", s_axi_rvalid, 1'b0);
    endtask

    task automatic pulseEvents(input logic [N_EVENTS-1:0] ev);
        event_in = ev;
        @(posedge clk); #1;
        mdl_event = mdl_event | ev;
        event_in  = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic applyStimulus(input int iterations);
        for (int it = 0; it < iterations; it++) begin
            for (int s = 0; s < N_STATUS; s++) status_in[32*s +: 32] = $urandom;
            if ($urandom_range(0, 3) == 0) pulseEvents(N_EVENTS'($urandom));
            else begin
                @(posedge clk); #1;
            end
            if ($urandom_range(0, 1) == 0)
                axiWrite($urandom_range(0, 15), $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 2), 1'b1);
            axiRead($urandom_range(0, 15), $urandom_range(0, 2));
            checkOutput("irq_rand", irq, expectedIrq());
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        aresetn       = 1'b0;
        s_axi_awaddr  = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0; s_axi_wstrb  = '0; s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_araddr  = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        status_in     = '0;
        event_in      = '0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_bvalid", s_axi_bvalid, 1'b0);
        checkOutput("rst_rvalid", s_axi_rvalid, 1'b0);
        checkOutput("rst_rdata", s_axi_rdata, 32'h0);
        checkOutput("rst_irq", irq, 1'b0);
        checkOutput("rst_run", run, 1'b0);
        checkOutput("rst_pulse", pulse_out, 32'h0);
        checkOutput("rst_ctrl_out", ctrl_out, 128'h0);
        aresetn = 1'b1;
        @(posedge clk); #1;

        axiRead(0, 0);
        axiRead(1, 0);

        axiWrite(1, 32'h0000_0001, 4'b0001, 0, 1'b1);
        checkOutput("run_set", run, 1'b1);
        axiWrite(1, 32'hFFFF_FF00, 4'b1110, 0, 1'b1);
        checkOutput("flags_merge", flags, 32'hFFFF_FF01);
        axiRead(1, 3);

        axiWrite(2, 32'h0000_0005, 4'hF, 0, 1'b1);
        axiRead(2, 0);

        axiWrite(4, 32'h0000_0008, 4'hF, 0, 1'b1);
        pulseEvents(8'h08);
        checkOutput("irq_event3", irq, 1'b1);
        axiRead(3, 0);
        event_in = 8'h08;
        axiWrite(3, 32'h0000_0008, 4'hF, 0, 1'b1);
        event_in = '0;
        axiRead(3, 0);
        axiWrite(3, 32'h0000_0008, 4'hF, 0, 1'b1);
        checkOutput("irq_cleared", irq, 1'b0);
        axiRead(3, 0);

        axiRead(15, 0);
        axiWrite(15, 32'hDEAD_BEEF, 4'hF, 5, 1'b1);
        axiRead(1, 0);

        axiWrite(5, 32'h0000_1234, 4'hF, 0, 1'b0);
        aresetn = 1'b0;
        @(posedge clk); #1;
        modelReset();
        checkOutput("rst_resp_bvalid", s_axi_bvalid, 1'b0);
        checkOutput("rst_resp_ctrl_out", ctrl_out, 128'h0);
        aresetn = 1'b1;
        @(posedge clk); #1;
        axiWrite(5, 32'h0000_1234, 4'hF, 0, 1'b1);
        axiRead(5, 0);
        axiWrite(2, 32'h8000_0000, 4'hF, 0, 1'b1);
        checkOutput("ctrl0_after_commit", ctrl_out[31:0], 32'h0000_1234);

        applyStimulus(150);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
